// File: rtl/led_pwm_fader.sv
// -----------------------------------------------------------------------------
// led_pwm_fader
//
// Sits between the LED chaser and the board pins. It takes the chaser's
// active-low pattern and drives each LED through its own PWM channel. A lit
// channel ramps up at UP_STEP per fade tick, and a dark channel decays at
// DOWN_STEP per fade tick, so the moving dot leaves a glowing tail.
//
// Optional feature: define LED_GAMMA_EN to map brightness to duty through
// (b*b) >> PWM_BITS, with full brightness mapped to full duty. This gives a
// perceptually linear fade. Without the macro the duty equals the brightness.
//
// Ports:
//   clk        in   1      system clock
//   rst_n      in   1      asynchronous active-low reset
//   led_in_n   in   N_LED  chaser pattern, active-low, asynchronous to clk
//   en         in   1      global enable; 0 darkens outputs and clears state
//   led_out_n  out  N_LED  registered PWM pin drive, active-low
//   tick       out  1      one-cycle pulse per fade tick (debug)
// -----------------------------------------------------------------------------
module led_pwm_fader #(
  parameter int CLK_HZ    = 50000000,
  parameter int FADE_HZ   = 1000,
  parameter int N_LED     = 6,
  parameter int PWM_BITS  = 8,
  parameter int UP_STEP   = 255,
  parameter int DOWN_STEP = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_LED-1:0] led_in_n,
  input  logic             en,
  output logic [N_LED-1:0] led_out_n,
  output logic             tick
);

  // Fade prescaler geometry; a ratio below 1 still gives a tick every cycle.
  localparam int TICK_DIV_RAW = CLK_HZ / FADE_HZ;
  localparam int TICK_DIV     = (TICK_DIV_RAW < 1) ? 1 : TICK_DIV_RAW;
  localparam int PRE_W        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  // PWM period is MAX cycles (0..MAX-1), so duty MAX is always on.
  localparam logic [PWM_BITS-1:0] PWM_LAST = PWM_BITS'((1 << PWM_BITS) - 2);
  localparam logic [PWM_BITS:0]   UP_W     = (PWM_BITS + 1)'(UP_STEP);
  localparam logic [PWM_BITS:0]   DN_W     = (PWM_BITS + 1)'(DOWN_STEP);

  // One fade step, saturating at MAX going up and at 0 going down.
  function automatic logic [PWM_BITS-1:0] bri_step(input logic [PWM_BITS-1:0] b,
                                                   input logic                up);
    logic [PWM_BITS:0] wide;
    if (up) begin
      wide = {1'b0, b} + UP_W;
      bri_step = wide[PWM_BITS] ? '1 : wide[PWM_BITS-1:0];
    end else begin
      wide = ({1'b0, b} >= DN_W) ? ({1'b0, b} - DN_W) : '0;
      bri_step = wide[PWM_BITS-1:0];
    end
  endfunction

  // Brightness to duty mapping.
  function automatic logic [PWM_BITS-1:0] duty_map(input logic [PWM_BITS-1:0] b);
`ifdef LED_GAMMA_EN
    logic [2*PWM_BITS-1:0] sq;
    sq = {{PWM_BITS{1'b0}}, b} * {{PWM_BITS{1'b0}}, b};
    // Full brightness must stay fully on, which the square alone cannot reach.
    duty_map = (b == '1) ? '1 : PWM_BITS'(sq >> PWM_BITS);
`else
    duty_map = b;
`endif
  endfunction

  // Two-flop synchroniser; resets to all dark.
  logic [N_LED-1:0] sync1_q, sync2_q;
  logic [N_LED-1:0] tgt;

  // NOTE: sequential state is written with <= only, so every flop samples the
  // pre-edge value of every other flop regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= led_in_n;
      sync2_q <= sync1_q;
    end
  end

  assign tgt = ~sync2_q;

  logic [PRE_W-1:0]    pre_q, pre_d;
  logic                tick_q, tick_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic [PWM_BITS-1:0] bri_q  [N_LED];
  logic [PWM_BITS-1:0] bri_d  [N_LED];
  logic [PWM_BITS-1:0] duty_q [N_LED];
  logic [PWM_BITS-1:0] duty_d [N_LED];
  logic [PWM_BITS-1:0] duty_eff [N_LED];
  logic [N_LED-1:0]    led_out_q, led_out_d;

  // NOTE: every signal gets a default at the top of the block, so no path
  // through the branches below can leave one unassigned and infer a latch.
  always_comb begin
    pre_d     = '0;
    tick_d    = 1'b0;
    pwm_d     = '0;
    led_out_d = '1;
    for (int i = 0; i < N_LED; i++) begin
      bri_d[i]    = '0;
      duty_d[i]   = '0;
      duty_eff[i] = '0;
    end

    if (en) begin
      pre_d  = (pre_q == PRE_LAST) ? '0 : pre_q + PRE_W'(1);
      tick_d = (pre_q == PRE_LAST);
      pwm_d  = (pwm_q == PWM_LAST) ? '0 : pwm_q + PWM_BITS'(1);
      for (int i = 0; i < N_LED; i++) begin
        // At the start of a period the freshly latched duty already governs
        // the output, so every cycle of a period uses the same duty. Because
        // the latch reads bri_q, a tick in the same cycle lands one period late.
        duty_eff[i]  = (pwm_q == '0) ? duty_map(bri_q[i]) : duty_q[i];
        duty_d[i]    = duty_eff[i];
        bri_d[i]     = tick_q ? bri_step(bri_q[i], tgt[i]) : bri_q[i];
        led_out_d[i] = ~(pwm_q < duty_eff[i]);
      end
    end
  end

  // NOTE: the per-channel arrays are ordinary flops, not a RAM, so they take
  // the asynchronous reset like every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q     <= '0;
      tick_q    <= 1'b0;
      pwm_q     <= '0;
      led_out_q <= '1;
      for (int i = 0; i < N_LED; i++) begin
        bri_q[i]  <= '0;
        duty_q[i] <= '0;
      end
    end else begin
      pre_q     <= pre_d;
      tick_q    <= tick_d;
      pwm_q     <= pwm_d;
      led_out_q <= led_out_d;
      for (int i = 0; i < N_LED; i++) begin
        bri_q[i]  <= bri_d[i];
        duty_q[i] <= duty_d[i];
      end
    end
  end

  assign led_out_n = led_out_q;
  assign tick      = tick_q;

endmodule

// File: tb/tb_led_pwm_fader.sv
// -----------------------------------------------------------------------------
// tb_led_pwm_fader
//
// Self-checking bench for led_pwm_fader with the sim parameters
// CLK_HZ=1000, FADE_HZ=100 (tick every 10 cycles), PWM_BITS=8. The reference
// model counts enabled cycles n since the last clear and derives the PWM
// phase (n mod 255) and the tick (n mod 10) arithmetically; brightness and
// duty follow the saturating step rules with plain integer maths.
// -----------------------------------------------------------------------------
module tb_led_pwm_fader;

  localparam int N_LED = 6;
  localparam int MAXV  = 255;
  localparam int DIV   = 10;
  localparam int UP    = 255;
  localparam int DN    = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b1;
  logic [N_LED-1:0] led_in_n = '1;
  logic [N_LED-1:0] led_out_n;
  logic             tick;

  led_pwm_fader #(
    .CLK_HZ   (1000),
    .FADE_HZ  (100),
    .N_LED    (N_LED),
    .PWM_BITS (8),
    .UP_STEP  (UP),
    .DOWN_STEP(DN)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .led_in_n (led_in_n),
    .en       (en),
    .led_out_n(led_out_n),
    .tick     (tick)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int               n;
  int               bri      [N_LED];
  int               duty     [N_LED];
  int               low_cnt  [N_LED];
  bit               per_valid;
  logic [N_LED-1:0] s1, s2;

  function automatic int gmap(input int b);
`ifdef LED_GAMMA_EN
    return (b == MAXV) ? MAXV : (b * b) / 256;
`else
    return b;
`endif
  endfunction

  task automatic model_reset();
    n = 0;
    s1 = '1;
    s2 = '1;
    per_valid = 1'b0;
    for (int i = 0; i < N_LED; i++) begin
      bri[i] = 0;
      duty[i] = 0;
      low_cnt[i] = 0;
    end
  endtask

  // Advance one clock: update the model from the pre-edge inputs, then
  // compare the outputs 1 time unit after the edge.
  task automatic step_cycle();
    logic [N_LED-1:0] tgt;
    logic [N_LED-1:0] exp_out;
    int               phase;
    bit               tick_pre;
    int               eff;
    @(posedge clk);
    tgt = ~s2;
    s2  = s1;
    s1  = led_in_n;
    exp_out = '1;
    phase = -1;
    if (!en) begin
      n = 0;
      per_valid = 1'b0;
      for (int i = 0; i < N_LED; i++) begin
        bri[i] = 0;
        duty[i] = 0;
        low_cnt[i] = 0;
      end
    end else begin
      phase    = n % MAXV;
      tick_pre = (n > 0) && (n % DIV == 0);
      if (phase == 0) begin
        per_valid = 1'b1;
        for (int i = 0; i < N_LED; i++) low_cnt[i] = 0;
      end
      for (int i = 0; i < N_LED; i++) begin
        eff = (phase == 0) ? gmap(bri[i]) : duty[i];
        if (phase == 0) duty[i] = eff;
        exp_out[i] = !(phase < eff);
        if (tick_pre) begin
          if (tgt[i]) bri[i] = (bri[i] + UP > MAXV) ? MAXV : bri[i] + UP;
          else        bri[i] = (bri[i] - DN < 0)    ? 0    : bri[i] - DN;
        end
      end
      n++;
    end
    #1;
    check("led_out_n", led_out_n, exp_out);
    check("tick", tick, (en && n > 0 && n % DIV == 0));
    if (phase >= 0) begin
      for (int i = 0; i < N_LED; i++) low_cnt[i] += (led_out_n[i] == 1'b0) ? 1 : 0;
      if (phase == MAXV - 1 && per_valid) begin
        for (int i = 0; i < N_LED; i++) check("period_low", low_cnt[i], duty[i]);
      end
    end
  endtask

  task automatic run(input int cycles);
    for (int k = 0; k < cycles; k++) step_cycle();
  endtask

  // Reset asserted asynchronously mid-cycle, held for a few edges.
  task automatic async_reset(input int hold);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_out", led_out_n, 6'b111111);
    check("rst_async_tick", tick, 1'b0);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      #1;
      check("rst_hold_out", led_out_n, 6'b111111);
    end
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int cnt;
    model_reset();

    // Reset held 5 cycles.
    rst_n = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check("rst_out", led_out_n, 6'b111111);
      check("rst_tick", tick, 1'b0);
    end
    rst_n = 1'b1;
    model_reset();

    // All dark: outputs stay dark.
    run(300);

    // Channel 0 lit: full brightness after the first tick, full duty after.
    led_in_n[0] = 1'b0;
    run(600);

    // Release: fade down 16 ticks.
    led_in_n[0] = 1'b1;
    run(800);

    // en dropped mid-fade, restored with input dark.
    led_in_n[0] = 1'b0;
    run(300);
    led_in_n[0] = 1'b1;
    run(40);
    en = 1'b0;
    run(3);
    check("en_off_out", led_out_n, 6'b111111);
    en = 1'b1;
    run(300);

    // Coincident tick and period start: target rises so that the tick at
    // n=510 is the first to see it; that period keeps the old duty.
    async_reset(2);
    run(505);
    led_in_n[1] = 1'b0;
    run(5);
    cnt = 0;
    for (int k = 0; k < MAXV; k++) begin
      step_cycle();
      cnt += (led_out_n[1] == 1'b0) ? 1 : 0;
    end
    check("simul_old_duty", cnt, 0);
    cnt = 0;
    for (int k = 0; k < MAXV; k++) begin
      step_cycle();
      cnt += (led_out_n[1] == 1'b0) ? 1 : 0;
    end
    check("simul_new_duty", cnt, MAXV);

    // Randomised patterns with occasional enable drops and one reset.
    for (int seg = 0; seg < 20; seg++) begin
      led_in_n = N_LED'($urandom);
      en = ($urandom_range(0, 9) != 0);
      run($urandom_range(20, 400));
      if (seg == 10) async_reset(1);
    end
    en = 1'b1;
    run(300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_pwm_fader.md
# led_pwm_fader

Downstream stage of the LED chaser. It consumes the chaser's active-low 6-bit pattern and drives the board LEDs through per-channel PWM. Each channel turns on at the attack rate and decays at the fade rate, so the moving dot leaves a glowing tail. The block sits between the pattern generator and the LED pins, and all of its logic runs in the 50 MHz system domain.

## Interface

Parameters:
- CLK_HZ, 50000000, clock frequency in Hz.
- FADE_HZ, 1000, brightness update rate in Hz; the fade tick period is CLK_HZ/FADE_HZ cycles (integer division, minimum 1).
- N_LED, 6, channel count.
- PWM_BITS, 8, brightness and duty width.
- UP_STEP, 255, brightness added per fade tick while a channel is lit.
- DOWN_STEP, 16, brightness subtracted per fade tick while a channel is dark.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- led_in_n  in  N_LED  pattern from the chaser, active-low (0 = lit); asynchronous to this block's logic.
- en  in  1  global enable; 0 forces all outputs dark and all brightness to 0.
- led_out_n  out  N_LED  PWM drive to the pins, active-low, registered.
- tick  out  1  one-cycle pulse on every fade tick, for debug and verification.

## Operation

- Input sync: led_in_n passes through a 2-flop synchroniser. The internal target is tgt[i] = ~sync[i].
- Fade prescaler: a counter runs 0..CLK_HZ/FADE_HZ-1 and wraps. tick goes high for exactly one cycle at the wrap.
- Brightness update: each channel holds bri[i] (PWM_BITS wide). Updates happen on tick only.
  - If tgt[i]=1: bri = min(bri+UP_STEP, MAX). The sum is computed one bit wider, then saturated.
  - If tgt[i]=0: bri = max(bri-DOWN_STEP, 0), saturating at 0.
  - MAX = 2^PWM_BITS-1.
- PWM counter: pwm_cnt runs 0..MAX-1 and wraps, giving a period of MAX cycles.
  - duty=MAX is therefore always-on; duty=0 is always-off.
- Duty latch: duty[i] loads from map(bri[i]) only when pwm_cnt==0. A duty change never occurs mid-period, so no glitched periods are produced.
- Output: led_out_n[i] is registered as ~(en && pwm_cnt < duty[i]).
- en=0: bri, duty and both counters clear synchronously. led_out_n goes to all-1 on the next edge. Normal operation resumes from brightness 0 when en returns to 1.
- Simultaneous tick and pwm_cnt==0: the duty latch takes the pre-update bri. The new value is used one PWM period later.

## Timing

- Reset values: led_out_n = all 1; tick = 0; bri, duty, pwm_cnt and prescaler = 0. The synchroniser flops reset to all 1 (all dark).
- Pattern latency: input edge → tgt is 2 cycles → bri change at the next tick → duty change at the next pwm_cnt==0 → pin change 1 cycle later.
- Worst-case visible latency is 2 + tick period + MAX + 1 cycles.
- Fade-out time from MAX to 0 is ceil(MAX/DOWN_STEP) ticks. With the defaults this is 16 ticks, i.e. 16 ms.
- Reset asserted mid-operation: all state returns to reset values immediately, and the outputs go dark asynchronously.

## Configuration

- LED_GAMMA_EN defined: map(b) = (b*b) >> PWM_BITS, except map(MAX) = MAX. This gives a perceptually linear fade.
  - Example: map(128)=64; map(16)=1; map(15)=0.
- LED_GAMMA_EN undefined: map(b) = b, a linear duty with no multiplier inferred.

## Test plan

All scenarios use the sim parameters CLK_HZ=1000, FADE_HZ=100 (tick every 10 cycles), PWM_BITS=8, UP_STEP=255, DOWN_STEP=16, with en=1 unless stated.

- Reset → led_out_n=6'b111111, tick=0. Reset is held 5 cycles, released, then led_in_n=all 1 → outputs stay all 1 indefinitely.
- led_in_n[0]=0 held → bri[0]=255 after the first tick. From the next pwm_cnt==0 onward, led_out_n[0]=0 on every cycle (100% duty).
- After that, led_in_n[0]=1 → bri[0] steps 239, 223, … down to 15, then 0 on the 16th tick. Each PWM period the low count equals the latched duty (linear build).
- LED_GAMMA_EN build with bri=128 → each 255-cycle period shows exactly 64 low cycles on that pin.
- en dropped mid-fade → led_out_n=all 1 on the next edge and bri=0. en restored with input dark → the output stays dark.
- Simultaneous tick and pwm_cnt==0 with a rising target → the current period uses the old duty; the following period shows duty 255.
